bcd_multi_digit_timer: RTL and testbench

//  Parametrised N-digit BCD up/down timer; next generation of the two-digit Digit cascade.

---
 rtl/bcd_multi_digit_timer.sv | 173 +++++++++++++++++
 tb/tb_bcd_multi_digit_timer.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_multi_digit_timer.sv
// bcd_multi_digit_timer
//   NUM_DIGITS-digit BCD up/down timer with run/stop control, direction,
//   optional MM:SS radix (odd digits count 0-5) and a terminal-count pulse.
//   The carry/borrow chain through all digits resolves in a single cycle.
//   Optional feature: define BCD_TIMER_AUTO_RELOAD_EN to reload the last
//   loaded value on the tick after terminal count instead of stopping.
module bcd_multi_digit_timer #(
   parameter int NUM_DIGITS  = 4,
   parameter int SEXAGESIMAL = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    tick,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_val,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    dir,
   output logic [4*NUM_DIGITS-1:0] count,
   output logic                    running,
   output logic                    done,
   output logic                    load_err
);

   localparam int W = 4 * NUM_DIGITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state, state_next;
   logic [W-1:0]   count_q, count_next;
   logic [W-1:0]   shadow_q, shadow_next;
   logic           done_q, done_next;
   logic           load_err_q, load_err_next;

   logic [W-1:0]   load_clamped;
   logic           load_over;
   logic [W-1:0]   term;
   logic [W-1:0]   stepped;

   // Highest value digit i may hold: 5 for the tens-of-seconds/minutes
   // positions in MM:SS mode, 9 otherwise.
   function automatic logic [3:0] digit_limit(input int i);
      return ((SEXAGESIMAL != 0) && ((i % 2) == 1)) ? 4'd5 : 4'd9;
   endfunction

   // Terminal value for a direction: all zeros counting down, all limits up.
   function automatic logic [W-1:0] terminal(input logic up);
      logic [W-1:0] t;
      t = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         t[4*i +: 4] = up ? digit_limit(i) : 4'd0;
      end
      return t;
   endfunction

   // One count step across the whole digit chain; the carry/borrow ripples
   // combinationally so e.g. 1000 -> 0999 happens in a single tick.
   function automatic logic [W-1:0] step(input logic [W-1:0] c, input logic up);
      logic [W-1:0] r;
      logic         carry;
      logic [3:0]   d;
      r     = c;
      carry = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         d = c[4*i +: 4];
         if (carry) begin
            if (up) begin
               if (d >= digit_limit(i)) begin
                  r[4*i +: 4] = 4'd0;
               end else begin
                  r[4*i +: 4] = d + 4'd1;
                  carry       = 1'b0;
               end
            end else begin
               if (d == 4'd0) begin
                  r[4*i +: 4] = digit_limit(i);
               end else begin
                  r[4*i +: 4] = d - 4'd1;
                  carry       = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   assign term    = terminal(dir);
   assign stepped = step(count_q, dir);

   // Clamp each preset digit to its limit and flag whether any digit was out of range.
   always_comb begin
      // NOTE: every variable written here gets a default first so no latch is inferred.
      load_clamped = '0;
      load_over    = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (load_val[4*i +: 4] > digit_limit(i)) begin
            load_clamped[4*i +: 4] = digit_limit(i);
            load_over              = 1'b1;
         end else begin
            load_clamped[4*i +: 4] = load_val[4*i +: 4];
         end
      end
   end

   // State and datapath registers; everything returns to zero/IDLE on reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         count_q    <= '0;
         shadow_q   <= '0;
         done_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state      <= state_next;
         count_q    <= count_next;
         shadow_q   <= shadow_next;
         done_q     <= done_next;
         load_err_q <= load_err_next;
      end
   end

   // Next-state logic with strict control priority: load > stop > start > tick.
   always_comb begin
      state_next    = state;
      count_next    = count_q;
      shadow_next   = shadow_q;
      done_next     = 1'b0;
      load_err_next = 1'b0;
      if (load) begin
         state_next    = IDLE;
         count_next    = load_clamped;
         shadow_next   = load_clamped;
         load_err_next = load_over;
      end else if (stop) begin
         if (state == RUN) begin
            state_next = IDLE;
         end
      end else if (start) begin
         if ((state != RUN) && (count_q != term)) begin
            state_next = RUN;
         end
      end else if (tick && (state == RUN)) begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
         if (count_q == term) begin
            count_next = shadow_q;
         end else begin
            count_next = stepped;
            done_next  = (stepped == term);
         end
`else
         count_next = stepped;
         if (stepped == term) begin
            done_next  = 1'b1;
            state_next = DONE;
         end
`endif
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      count    = count_q;
      running  = (state == RUN);
      done     = done_q;
      load_err = load_err_q;
   end

endmodule

// File: tb/tb_bcd_multi_digit_timer.sv
// tb_bcd_multi_digit_timer
//   Runs a decimal instance and an MM:SS instance side by side from the same
//   stimulus and compares both against a mixed-radix integer model.
//   Honours BCD_TIMER_AUTO_RELOAD_EN in the same way as the design.
module tb_bcd_multi_digit_timer;

   localparam int W      = 16;
   localparam int S_IDLE = 0;
   localparam int S_RUN  = 1;
   localparam int S_DONE = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, dir = 1'b0;
   logic [W-1:0] load_val = '0;

   logic [1:0][W-1:0] cnt_o;
   logic [1:0]        run_o, done_o, err_o;

   int total = 0;
   int bad   = 0;

   // Model state per instance: 0 = decimal, 1 = MM:SS.
   int m_val[2], m_shadow[2], m_st[2];
   bit m_done[2], m_err[2];

   always #5 clk = ~clk;

   bcd_multi_digit_timer #(.NUM_DIGITS(4), .SEXAGESIMAL(0)) dut_dec (
      .clk(clk), .rst(rst), .tick(tick), .load(load), .load_val(load_val),
      .start(start), .stop(stop), .dir(dir),
      .count(cnt_o[0]), .running(run_o[0]), .done(done_o[0]), .load_err(err_o[0])
   );

   bcd_multi_digit_timer #(.NUM_DIGITS(4), .SEXAGESIMAL(1)) dut_sex (
      .clk(clk), .rst(rst), .tick(tick), .load(load), .load_val(load_val),
      .start(start), .stop(stop), .dir(dir),
      .count(cnt_o[1]), .running(run_o[1]), .done(done_o[1]), .load_err(err_o[1])
   );

   // ---------------- reference model (integer, mixed radix) ----------------
   function automatic int radix(int m, int i);
      return (m == 1 && (i % 2) == 1) ? 6 : 10;
   endfunction

   function automatic int weight(int m, int i);
      int p = 1;
      for (int j = 0; j < i; j++) p = p * radix(m, j);
      return p;
   endfunction

   function automatic int maxval(int m);
      return weight(m, 4) - 1;
   endfunction

   function automatic int from_bcd(int m, logic [W-1:0] b);
      int v = 0;
      int d;
      for (int i = 0; i < 4; i++) begin
         d = int'(b[4*i +: 4]);
         if (d > radix(m, i) - 1) d = radix(m, i) - 1;
         v = v + d * weight(m, i);
      end
      return v;
   endfunction

   function automatic bit clamps(int m, logic [W-1:0] b);
      bit c = 1'b0;
      for (int i = 0; i < 4; i++)
         if (int'(b[4*i +: 4]) > radix(m, i) - 1) c = 1'b1;
      return c;
   endfunction

   function automatic logic [W-1:0] to_bcd(int m, int v);
      logic [W-1:0] r = '0;
      for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / weight(m, i)) % radix(m, i));
      return r;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_val[m] = 0; m_shadow[m] = 0; m_st[m] = S_IDLE;
         m_done[m] = 1'b0; m_err[m] = 1'b0;
      end
   endtask

   task automatic model_edge();
      for (int m = 0; m < 2; m++) begin
         int term;
         int modulus;
         term    = dir ? maxval(m) : 0;
         modulus = maxval(m) + 1;
         m_done[m] = 1'b0;
         m_err[m]  = 1'b0;
         if (load) begin
            m_val[m]    = from_bcd(m, load_val);
            m_shadow[m] = m_val[m];
            m_st[m]     = S_IDLE;
            m_err[m]    = clamps(m, load_val);
         end else if (stop) begin
            if (m_st[m] == S_RUN) m_st[m] = S_IDLE;
         end else if (start) begin
            if (m_st[m] != S_RUN && m_val[m] != term) m_st[m] = S_RUN;
         end else if (tick && m_st[m] == S_RUN) begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
            if (m_val[m] == term) begin
               m_val[m] = m_shadow[m];
            end else begin
               m_val[m]  = dir ? (m_val[m] + 1) % modulus : (m_val[m] + modulus - 1) % modulus;
               m_done[m] = (m_val[m] == term);
            end
`else
            m_val[m] = dir ? (m_val[m] + 1) % modulus : (m_val[m] + modulus - 1) % modulus;
            if (m_val[m] == term) begin
               m_done[m] = 1'b1;
               m_st[m]   = S_DONE;
            end
`endif
         end
      end
   endtask

   // Step encoding: flags {load, start, stop, tick, dir} then load_val.
   function automatic logic [20:0] op(logic [4:0] f, logic [15:0] lv);
      return {f, lv};
   endfunction

   // Apply one cycle of stimulus, advance the model, and settle past the edge.
   task automatic cyc(input logic [20:0] v);
      {load, start, stop, tick, dir} = v[20:16];
      load_val = v[15:0];
      model_edge();
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         total++;
         if (cnt_o[m] !== 16'h0000) begin
            bad++; $display("FAIL reset inst%0d count got=%h want=0000", m, cnt_o[m]);
         end
         total++;
         if ({run_o[m], done_o[m], err_o[m]} !== 3'b000) begin
            bad++; $display("FAIL reset inst%0d run/done/err got=%b want=000", m, {run_o[m], done_o[m], err_o[m]});
         end
      end
      rst = 1'b1;
   endtask

   task automatic test_terminal();
      logic [20:0] seq [$];
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      seq = '{op(5'b10000, 16'h0002), op(5'b01000, 0), op(5'b00010, 0), op(5'b00010, 0),
              op(5'b00010, 0), op(5'b00000, 0), op(5'b01000, 0)};
`else
      seq = '{op(5'b10000, 16'h0003), op(5'b01000, 0), op(5'b00010, 0), op(5'b00010, 0),
              op(5'b00010, 0), op(5'b00000, 0), op(5'b01000, 0)};
`endif
      foreach (seq[k]) begin
         cyc(seq[k]);
         for (int m = 0; m < 2; m++) begin
            total++;
            if (cnt_o[m] !== to_bcd(m, m_val[m])) begin
               bad++; $display("FAIL terminal step%0d inst%0d count got=%h want=%h", k, m, cnt_o[m], to_bcd(m, m_val[m]));
            end
            total++;
            if ({run_o[m], done_o[m], err_o[m]} !== {m_st[m] == S_RUN, m_done[m], m_err[m]}) begin
               bad++; $display("FAIL terminal step%0d inst%0d run/done/err got=%b want=%b", k, m,
                               {run_o[m], done_o[m], err_o[m]}, {m_st[m] == S_RUN, m_done[m], m_err[m]});
            end
         end
`ifdef BCD_TIMER_AUTO_RELOAD_EN
         if (k == 3) begin
            total++;
            if ({cnt_o[0], done_o, run_o} !== {16'h0000, 2'b11, 2'b11}) begin
               bad++; $display("FAIL reload_hit count/done/run got=%h/%b/%b want=0000/11/11", cnt_o[0], done_o, run_o);
            end
         end
         if (k == 4) begin
            total++;
            if ({cnt_o[0], done_o, run_o} !== {16'h0002, 2'b00, 2'b11}) begin
               bad++; $display("FAIL reload_wrap count/done/run got=%h/%b/%b want=0002/00/11", cnt_o[0], done_o, run_o);
            end
         end
`else
         if (k == 4) begin
            total++;
            if ({cnt_o[0], done_o, run_o} !== {16'h0000, 2'b11, 2'b00}) begin
               bad++; $display("FAIL countdown_end count/done/run got=%h/%b/%b want=0000/11/00", cnt_o[0], done_o, run_o);
            end
         end
         if (k == 6) begin
            total++;
            if (run_o !== 2'b00) begin
               bad++; $display("FAIL start_in_done run got=%b want=00", run_o);
            end
         end
`endif
      end
   endtask

   task automatic test_borrow_chain();
      logic [20:0] seq [$];
      seq = '{op(5'b10000, 16'h1000), op(5'b01000, 0), op(5'b00010, 0),
              op(5'b10000, 16'h0100), op(5'b01000, 0), op(5'b00010, 0),
              op(5'b10001, 16'h0959), op(5'b01001, 0), op(5'b00011, 0)};
      foreach (seq[k]) begin
         cyc(seq[k]);
         for (int m = 0; m < 2; m++) begin
            total++;
            if (cnt_o[m] !== to_bcd(m, m_val[m])) begin
               bad++; $display("FAIL chain step%0d inst%0d count got=%h want=%h", k, m, cnt_o[m], to_bcd(m, m_val[m]));
            end
         end
         if (k == 2) begin
            total++;
            if (cnt_o !== {16'h0959, 16'h0999}) begin
               bad++; $display("FAIL borrow_1000 got=%h want=0959_0999", cnt_o);
            end
         end
         if (k == 5) begin
            total++;
            if (cnt_o !== {16'h0059, 16'h0099}) begin
               bad++; $display("FAIL borrow_0100 got=%h want=0059_0099", cnt_o);
            end
         end
         if (k == 8) begin
            total++;
            if (cnt_o !== {16'h1000, 16'h0960}) begin
               bad++; $display("FAIL carry_0959 got=%h want=1000_0960", cnt_o);
            end
         end
      end
   endtask

   task automatic test_clamp();
      logic [20:0] seq [$];
      seq = '{op(5'b10000, 16'h00A7), op(5'b00000, 0)};
      foreach (seq[k]) begin
         cyc(seq[k]);
         for (int m = 0; m < 2; m++) begin
            total++;
            if ({cnt_o[m], err_o[m]} !== {to_bcd(m, m_val[m]), m_err[m]}) begin
               bad++; $display("FAIL clamp step%0d inst%0d count/err got=%h/%b want=%h/%b", k, m,
                               cnt_o[m], err_o[m], to_bcd(m, m_val[m]), m_err[m]);
            end
         end
         if (k == 0) begin
            total++;
            if ({cnt_o, err_o} !== {16'h0057, 16'h0097, 2'b11}) begin
               bad++; $display("FAIL clamp_a7 count=%h err=%b want 0057_0097 err=11", cnt_o, err_o);
            end
         end
         if (k == 1) begin
            total++;
            if (err_o !== 2'b00) begin
               bad++; $display("FAIL clamp_pulse err got=%b want=00", err_o);
            end
         end
      end
   endtask

   task automatic test_priority();
      logic [20:0] seq [$];
      seq = '{op(5'b10000, 16'h0042), op(5'b01000, 0), op(5'b00010, 0),
              op(5'b10010, 16'h0055), op(5'b01000, 0), op(5'b00110, 0), op(5'b00010, 0)};
      foreach (seq[k]) begin
         cyc(seq[k]);
         for (int m = 0; m < 2; m++) begin
            total++;
            if ({cnt_o[m], run_o[m]} !== {to_bcd(m, m_val[m]), m_st[m] == S_RUN}) begin
               bad++; $display("FAIL priority step%0d inst%0d count/run got=%h/%b want=%h/%b", k, m,
                               cnt_o[m], run_o[m], to_bcd(m, m_val[m]), m_st[m] == S_RUN);
            end
         end
         if (k == 3 || k == 6) begin
            total++;
            if ({cnt_o[0], run_o} !== {16'h0055, 2'b00}) begin
               bad++; $display("FAIL priority_hold step%0d count/run got=%h/%b want=0055/00", k, cnt_o[0], run_o);
            end
         end
      end
   endtask

   task automatic test_start_at_terminal();
      logic [20:0] seq [$];
      seq = '{op(5'b10000, 16'h0000), op(5'b01000, 0), op(5'b01001, 0), op(5'b00011, 0)};
      foreach (seq[k]) begin
         cyc(seq[k]);
         for (int m = 0; m < 2; m++) begin
            total++;
            if ({cnt_o[m], run_o[m], done_o[m]} !== {to_bcd(m, m_val[m]), m_st[m] == S_RUN, m_done[m]}) begin
               bad++; $display("FAIL start_term step%0d inst%0d count/run/done got=%h/%b/%b want=%h/%b/%b", k, m,
                               cnt_o[m], run_o[m], done_o[m], to_bcd(m, m_val[m]), m_st[m] == S_RUN, m_done[m]);
            end
         end
         if (k == 1) begin
            total++;
            if (run_o !== 2'b00) begin
               bad++; $display("FAIL start_ignored run got=%b want=00", run_o);
            end
         end
         if (k == 3) begin
            total++;
            if ({cnt_o, run_o} !== {16'h0001, 16'h0001, 2'b11}) begin
               bad++; $display("FAIL up_from_zero count=%h run=%b want 0001_0001 run=11", cnt_o, run_o);
            end
         end
      end
   endtask

   task automatic test_up_terminal();
      logic [20:0] seq [$];
      seq = '{op(5'b10000, 16'h9998), op(5'b01001, 0), op(5'b00011, 0), op(5'b00011, 0), op(5'b00001, 0)};
      foreach (seq[k]) begin
         cyc(seq[k]);
         for (int m = 0; m < 2; m++) begin
            total++;
            if ({cnt_o[m], run_o[m], done_o[m], err_o[m]} !==
                {to_bcd(m, m_val[m]), m_st[m] == S_RUN, m_done[m], m_err[m]}) begin
               bad++; $display("FAIL up_term step%0d inst%0d count/run/done/err got=%h/%b/%b/%b want=%h/%b/%b/%b", k, m,
                               cnt_o[m], run_o[m], done_o[m], err_o[m],
                               to_bcd(m, m_val[m]), m_st[m] == S_RUN, m_done[m], m_err[m]);
            end
         end
         if (k == 0) begin
            total++;
            if (err_o !== 2'b10) begin
               bad++; $display("FAIL up_term_err got=%b want=10", err_o);
            end
         end
         if (k == 2) begin
            total++;
            if ({cnt_o, done_o} !== {16'h5959, 16'h9999, 2'b11}) begin
               bad++; $display("FAIL up_term_hit count=%h done=%b want 5959_9999 done=11", cnt_o, done_o);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] lv;
      logic [4:0]  f;
      logic        d;
      d = 1'b0;
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 31) == 0) d = ~d;
         f = {($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 23) == 0), ($urandom_range(0, 1) == 0), d};
         if ($urandom_range(0, 1) == 0)
            lv = {8'h00, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
         else
            lv = 16'($urandom);
         cyc(op(f, lv));
         for (int m = 0; m < 2; m++) begin
            total++;
            if ({cnt_o[m], run_o[m], done_o[m], err_o[m]} !==
                {to_bcd(m, m_val[m]), m_st[m] == S_RUN, m_done[m], m_err[m]}) begin
               bad++; $display("FAIL random cyc%0d inst%0d count/run/done/err got=%h/%b/%b/%b want=%h/%b/%b/%b", k, m,
                               cnt_o[m], run_o[m], done_o[m], err_o[m],
                               to_bcd(m, m_val[m]), m_st[m] == S_RUN, m_done[m], m_err[m]);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      cyc(op(5'b10000, 16'h0020));
      cyc(op(5'b01000, 0));
      cyc(op(5'b00010, 0));
      {load, start, stop, tick, dir} = 5'b00000;
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      for (int m = 0; m < 2; m++) begin
         total++;
         if ({cnt_o[m], run_o[m], done_o[m], err_o[m]} !== {16'h0000, 3'b000}) begin
            bad++; $display("FAIL async_reset inst%0d count/run/done/err got=%h/%b/%b/%b want=0000/0/0/0", m,
                            cnt_o[m], run_o[m], done_o[m], err_o[m]);
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      model_reset();
      #1;
      test_reset();
      test_terminal();
      test_borrow_chain();
      test_clamp();
      test_priority();
      test_start_at_terminal();
      test_up_terminal();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
